// File: rtl/lshift_load_sched.sv
// Load scheduler for the rotating shift register: buffers bytes in a small FIFO
// and issues one load strobe per byte, then waits HOLD cycles for the rotation.
module lshift_load_sched #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int HOLD  = 8
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         in_valid,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         in_ready,
   input  logic                         flush,
   output logic [WIDTH-1:0]             load_val,
   output logic                         load_en,
   output logic                         busy,
   output logic                         done,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         state_dbg
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [7:0]    HOLD_V   = 8'(HOLD);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       hcnt_q, hcnt_d;
   logic [WIDTH-1:0] load_val_d;
   logic             load_en_d, busy_d, done_d;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             push, pop;

   // Stream handshake: a byte transfers on a rising edge where in_valid and
   // in_ready are both high. in_ready never looks at in_valid or at a pop
   // scheduled for the same edge, so a full FIFO refuses even while draining.
   assign in_ready  = rstn && (count != CNT_FULL) && !flush;
   assign push      = in_valid && in_ready;
   assign state_dbg = state_q;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= in_data;
   end

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (!rstn || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !pop)
            count <= count + CNT_ONE;
         else if (pop && !push)
            count <= count - CNT_ONE;
      end
   end

   always_comb begin
      state_d    = state_q;
      hcnt_d     = hcnt_q;
      load_val_d = load_val;
      load_en_d  = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      pop        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (count != '0) begin
               pop        = 1'b1;
               load_val_d = mem[rd_ptr];
               load_en_d  = 1'b1;
               busy_d     = 1'b1;
               hcnt_d     = HOLD_V;
               done_d     = (HOLD == 0);
               state_d    = (HOLD > 0) ? ST_HOLD : ST_IDLE;
            end
         end
         ST_HOLD: begin
            busy_d = 1'b1;
            if (hcnt_q > 8'd1) begin
               hcnt_d = hcnt_q - 8'd1;
            end else begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Flush aborts a hold without a done pulse but keeps the last loaded byte.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= ST_IDLE;
         hcnt_q   <= '0;
         load_val <= '0;
         load_en  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else if (flush) begin
         state_q  <= ST_IDLE;
         hcnt_q   <= '0;
         load_en  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q  <= state_d;
         hcnt_q   <= hcnt_d;
         load_val <= load_val_d;
         load_en  <= load_en_d;
         busy     <= busy_d;
         done     <= done_d;
      end
   end

endmodule

// File: tb/tb_lshift_load_sched.sv
// Directed bench for lshift_load_sched: three instances with HOLD = 8, 0 and 3,
// inputs driven and outputs sampled on the falling clock edge.
module tb_lshift_load_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   localparam int D8 = 0;
   localparam int D0 = 1;
   localparam int D3 = 2;

   logic [2:0] rstn     = 3'b000;
   logic [2:0] in_valid = 3'b000;
   logic [2:0] flush    = 3'b000;
   logic [7:0] in_data [3];
   wire  [2:0] in_ready, load_en, busy, done, state_dbg;
   wire  [7:0] load_val [3];
   wire  [2:0] count [3];

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] exp_q[$];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      lshift_load_sched #(
         .WIDTH(8),
         .DEPTH(4),
         .HOLD((g == 0) ? 8 : ((g == 1) ? 0 : 3))
      ) u_dut (
         .clk       (clk),
         .rstn      (rstn[g]),
         .in_valid  (in_valid[g]),
         .in_data   (in_data[g]),
         .in_ready  (in_ready[g]),
         .flush     (flush[g]),
         .load_val  (load_val[g]),
         .load_en   (load_en[g]),
         .busy      (busy[g]),
         .done      (done[g]),
         .count     (count[g]),
         .state_dbg (state_dbg[g])
      );
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      for (int d = 0; d < 3; d++) begin
         n_checks++;
         if ({in_ready[d], load_en[d], load_val[d], busy[d], done[d], count[d], state_dbg[d]} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs dut%0d: got %h expected 0", d,
                     {in_ready[d], load_en[d], load_val[d], busy[d], done[d], count[d], state_dbg[d]});
         end
      end
      rstn = 3'b111;
      #1;
      n_checks++;
      if (in_ready !== 3'b111) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b expected 111", in_ready);
      end
      tick();
   endtask

   task automatic test_single();
      int busy_cycles;
      in_valid[D8] = 1'b1;
      in_data[D8]  = 8'hA5;
      #1;
      n_checks++;
      if (in_ready[D8] !== 1'b1) begin
         n_fail++;
         $display("FAIL single_ready: got %b expected 1", in_ready[D8]);
      end
      tick();
      in_valid[D8] = 1'b0;
      n_checks++;
      if ({load_en[D8], count[D8]} !== {1'b0, 3'd1}) begin
         n_fail++;
         $display("FAIL single_accept: got %h expected 1", {load_en[D8], count[D8]});
      end
      tick();
      n_checks++;
      if ({load_en[D8], load_val[D8], busy[D8], done[D8], count[D8]} !== {1'b1, 8'hA5, 1'b1, 1'b0, 3'd0}) begin
         n_fail++;
         $display("FAIL single_load: got %h expected %h",
                  {load_en[D8], load_val[D8], busy[D8], done[D8], count[D8]}, {1'b1, 8'hA5, 1'b1, 1'b0, 3'd0});
      end
      busy_cycles = 1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (busy[D8]) busy_cycles++;
         n_checks++;
         if ({load_en[D8], busy[D8], done[D8]} !== {1'b0, 1'b1, (i == 8)}) begin
            n_fail++;
            $display("FAIL single_hold_%0d: got %b expected %b", i,
                     {load_en[D8], busy[D8], done[D8]}, {1'b0, 1'b1, (i == 8)});
         end
      end
      tick();
      n_checks++;
      if ({load_en[D8], busy[D8], done[D8], count[D8]} !== 6'd0 || busy_cycles != 9) begin
         n_fail++;
         $display("FAIL single_end: got %b busy_cycles %0d expected 0 and 9",
                  {load_en[D8], busy[D8], done[D8], count[D8]}, busy_cycles);
      end
   endtask

   task automatic test_fill();
      int idx = 0, last = -1, loads = 0, dones = 0, acc6 = -1;
      logic [7:0] e;
      exp_q.delete();
      for (int c = 0; c < 60; c++) begin
         if (load_en[D8]) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            n_checks++;
            if (load_val[D8] !== e) begin
               n_fail++;
               $display("FAIL fill_order: got %h expected %h", load_val[D8], e);
            end
            if (last >= 0) begin
               n_checks++;
               if (c - last != 9) begin
                  n_fail++;
                  $display("FAIL fill_spacing: got %0d expected 9", c - last);
               end
            end
            last = c;
            loads++;
         end
         if (done[D8]) dones++;
         n_checks++;
         if (in_ready[D8] !== (count[D8] != 3'd4)) begin
            n_fail++;
            $display("FAIL fill_ready: got %b with count %0d", in_ready[D8], count[D8]);
         end
         if (c == 5) begin
            n_checks++;
            if ({count[D8], in_ready[D8]} !== {3'd4, 1'b0}) begin
               n_fail++;
               $display("FAIL fill_full: got %b expected 1000", {count[D8], in_ready[D8]});
            end
         end
         if (idx < 6) begin
            in_valid[D8] = 1'b1;
            in_data[D8]  = 8'(idx + 1);
            if (in_ready[D8]) begin
               exp_q.push_back(in_data[D8]);
               if (idx == 5) acc6 = c;
               idx++;
            end
         end else begin
            in_valid[D8] = 1'b0;
         end
         tick();
      end
      n_checks++;
      if (loads != 6 || dones != 6 || acc6 != 11 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL fill_totals: got loads %0d dones %0d accept6 %0d left %0d expected 6 6 11 0",
                  loads, dones, acc6, exp_q.size());
      end
      n_checks++;
      if ({busy[D8], count[D8]} !== 4'd0) begin
         n_fail++;
         $display("FAIL fill_idle: got %b expected 0", {busy[D8], count[D8]});
      end
   endtask

   task automatic test_hold0();
      logic [7:0] vals [3];
      vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
      for (int c = 0; c < 6; c++) begin
         if (c >= 2 && c <= 4) begin
            n_checks++;
            if ({load_en[D0], load_val[D0], done[D0], busy[D0]} !== {1'b1, vals[c-2], 1'b1, 1'b1}) begin
               n_fail++;
               $display("FAIL hold0_load_%0d: got %h expected %h", c - 2,
                        {load_en[D0], load_val[D0], done[D0], busy[D0]}, {1'b1, vals[c-2], 1'b1, 1'b1});
            end
         end
         if (c == 5) begin
            n_checks++;
            if ({load_en[D0], done[D0], busy[D0], count[D0]} !== 6'd0) begin
               n_fail++;
               $display("FAIL hold0_end: got %b expected 0", {load_en[D0], done[D0], busy[D0], count[D0]});
            end
         end
         in_valid[D0] = (c < 3);
         in_data[D0]  = (c < 3) ? vals[c] : 8'h00;
         tick();
      end
   endtask

   task automatic test_flush_mid();
      int stray = 0;
      in_valid[D8] = 1'b1; in_data[D8] = 8'h3C; tick();
      in_data[D8] = 8'hAA; tick();
      n_checks++;
      if ({load_en[D8], load_val[D8]} !== {1'b1, 8'h3C}) begin
         n_fail++;
         $display("FAIL flush_load: got %h expected 13c", {load_en[D8], load_val[D8]});
      end
      in_data[D8] = 8'hBB; tick();
      in_valid[D8] = 1'b0; tick();
      tick();
      n_checks++;
      if ({busy[D8], count[D8]} !== {1'b1, 3'd2}) begin
         n_fail++;
         $display("FAIL flush_pre: got %b expected 1010", {busy[D8], count[D8]});
      end
      flush[D8] = 1'b1; in_valid[D8] = 1'b1; in_data[D8] = 8'hCC;
      #1;
      n_checks++;
      if (in_ready[D8] !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_ready: got %b expected 0", in_ready[D8]);
      end
      tick();
      flush[D8] = 1'b0; in_valid[D8] = 1'b0;
      n_checks++;
      if ({load_en[D8], busy[D8], done[D8], count[D8], state_dbg[D8]} !== 7'd0) begin
         n_fail++;
         $display("FAIL flush_after: got %b expected 0", {load_en[D8], busy[D8], done[D8], count[D8], state_dbg[D8]});
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         if (load_en[D8] || done[D8] || busy[D8]) stray++;
      end
      n_checks++;
      if (stray != 0) begin
         n_fail++;
         $display("FAIL flush_quiet: got %0d active cycles expected 0", stray);
      end
   endtask

   task automatic test_reset_mid();
      int stray = 0;
      in_valid[D8] = 1'b1; in_data[D8] = 8'h5A; tick();
      in_data[D8] = 8'h66; tick();
      in_valid[D8] = 1'b0;
      n_checks++;
      if ({load_en[D8], load_val[D8]} !== {1'b1, 8'h5A}) begin
         n_fail++;
         $display("FAIL rstmid_load: got %h expected 15a", {load_en[D8], load_val[D8]});
      end
      tick(); tick(); tick();
      rstn[D8] = 1'b0;
      #1;
      n_checks++;
      if (in_ready[D8] !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_ready: got %b expected 0", in_ready[D8]);
      end
      tick();
      n_checks++;
      if ({load_en[D8], load_val[D8], busy[D8], done[D8], count[D8], state_dbg[D8]} !== 15'd0) begin
         n_fail++;
         $display("FAIL rstmid_outputs: got %h expected 0",
                  {load_en[D8], load_val[D8], busy[D8], done[D8], count[D8], state_dbg[D8]});
      end
      rstn[D8] = 1'b1; in_valid[D8] = 1'b1; in_data[D8] = 8'h77;
      tick();
      in_valid[D8] = 1'b0;
      n_checks++;
      if ({load_en[D8], count[D8]} !== {1'b0, 3'd1}) begin
         n_fail++;
         $display("FAIL rstmid_accept: got %b expected 0001", {load_en[D8], count[D8]});
      end
      tick();
      n_checks++;
      if ({load_en[D8], load_val[D8]} !== {1'b1, 8'h77}) begin
         n_fail++;
         $display("FAIL rstmid_reload: got %h expected 177", {load_en[D8], load_val[D8]});
      end
      for (int i = 0; i < 12; i++) begin
         tick();
         if (load_en[D8]) stray++;
      end
      n_checks++;
      if (stray != 0) begin
         n_fail++;
         $display("FAIL rstmid_stale_load: got %0d loads expected 0", stray);
      end
   endtask

   task automatic test_wrap();
      int sent = 0, loads = 0, last = -100, iter = 0;
      logic [7:0] e;
      exp_q.delete();
      while (loads < 20 && iter < 600) begin
         if (load_en[D3]) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            n_checks++;
            if (load_val[D3] !== e) begin
               n_fail++;
               $display("FAIL wrap_order: got %h expected %h", load_val[D3], e);
            end
            n_checks++;
            if (iter - last < 4) begin
               n_fail++;
               $display("FAIL wrap_spacing: got %0d expected >= 4", iter - last);
            end
            last = iter;
            loads++;
         end
         n_checks++;
         if (count[D3] > 3'd4 || in_ready[D3] !== (count[D3] != 3'd4)) begin
            n_fail++;
            $display("FAIL wrap_count: got count %0d ready %b", count[D3], in_ready[D3]);
         end
         if (sent < 20 && $urandom_range(0, 2) != 0) begin
            in_valid[D3] = 1'b1;
            in_data[D3]  = 8'($urandom_range(0, 255));
            if (in_ready[D3]) begin
               exp_q.push_back(in_data[D3]);
               sent++;
            end
         end else begin
            in_valid[D3] = 1'b0;
         end
         tick();
         iter++;
      end
      in_valid[D3] = 1'b0;
      n_checks++;
      if (loads != 20 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL wrap_drain: got %0d loads, %0d left expected 20, 0", loads, exp_q.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) in_data[i] = 8'h00;
      @(negedge clk);
      test_reset();
      test_single();
      test_fill();
      test_hold0();
      test_flush_mid();
      test_reset_mid();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
